// File: rtl/mem_arbiter.sv
// Shared physical-memory port arbiter between the I-side and D-side L1 caches.
// The D side has fixed priority. A streak counter bounds how many consecutive
// D grants can occur while I is waiting. One line transaction is in flight at a time.
module mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int LINE_W       = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state_r;
   state_t     state_next_s;
   logic [3:0] streak_r;
   logic       grant_i_s;
   logic       grant_d_s;
   logic       done_s;

   // Read data is a plain copy of memory data; only the resp pulse qualifies it.
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

   // Completion pulses follow pmem_resp in the matching serve state. They are
   // suppressed while reset is asserted so that a late memory response is dropped.
   assign i_resp = (state_r == SERVE_I) && pmem_resp && !rst;
   assign d_resp = (state_r == SERVE_D) && pmem_resp && !rst;

   // Next-state and grant decode: starvation override first, then D priority, then I.
   always_comb begin
      state_next_s = state_r;
      grant_i_s    = 1'b0;
      grant_d_s    = 1'b0;
      done_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (i_read && (streak_r == LIMIT)) begin
               state_next_s = SERVE_I;
               grant_i_s    = 1'b1;
            end else if (d_read || d_write) begin
               state_next_s = SERVE_D;
               grant_d_s    = 1'b1;
            end else if (i_read) begin
               state_next_s = SERVE_I;
               grant_i_s    = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) begin
               state_next_s = IDLE;
               done_s       = 1'b1;
            end else begin
               state_next_s = state_r;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Streak of D grants made while I waits. It saturates at the limit and never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         streak_r <= 4'd0;
      end else if (grant_i_s) begin
         streak_r <= 4'd0;
      end else if (grant_d_s) begin
         if (!i_read) begin
            streak_r <= 4'd0;
         end else if (streak_r < LIMIT) begin
            streak_r <= streak_r + 4'd1;
         end else begin
            streak_r <= streak_r;
         end
      end else begin
         streak_r <= streak_r;
      end
   end

   // Memory-side registers: latch the transaction on grant, drop strobes on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else if (grant_d_s) begin
         pmem_address <= d_address;
         pmem_wdata   <= d_wdata;
         pmem_write   <= d_write;
         pmem_read    <= !d_write;
      end else if (grant_i_s) begin
         pmem_address <= i_address;
         pmem_read    <= 1'b1;
         pmem_write   <= 1'b0;
      end else if (done_s) begin
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
      end else begin
         pmem_read    <= pmem_read;
         pmem_write   <= pmem_write;
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared physical-memory port between the instruction-fetch cache (I side) and the MEM-stage data cache (D side) of the pipelined LC-3b.
- Grants one outstanding line transaction at a time.
- D side has fixed priority, with a starvation bound that guarantees forward progress for instruction fetch.
- Sits between the two L1 caches and the pmem interface; has no knowledge of opcodes or pipeline state.

Parameters:
- ADDR_W, 16, byte address width.
- LINE_W, 128, cache line width in bits.
- STARVE_LIMIT, 4, max consecutive D grants while I is pending before I must be granted; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- i_read  in  1  I-side line read request; held until i_resp.
- i_address  in  ADDR_W  I-side line address.
- i_rdata  out  LINE_W  I-side read data, valid when i_resp=1.
- i_resp  out  1  I-side completion pulse.
- d_read  in  1  D-side line read request; held until d_resp.
- d_write  in  1  D-side line write (writeback) request; held until d_resp.
- d_address  in  ADDR_W  D-side line address.
- d_wdata  in  LINE_W  D-side write data.
- d_rdata  out  LINE_W  D-side read data, valid when d_resp=1.
- d_resp  out  1  D-side completion pulse.
- pmem_read  out  1  memory read strobe, registered.
- pmem_write  out  1  memory write strobe, registered.
- pmem_address  out  ADDR_W  latched transaction address, registered.
- pmem_wdata  out  LINE_W  latched write data, registered.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory completion, one-cycle pulse.

Behaviour:
- Reset values: state IDLE; streak counter 0; pmem_read, pmem_write = 0; pmem_address, pmem_wdata = 0. i_resp and d_resp are 0 during and after reset until a served transaction completes.
- FSM states:
  - IDLE: evaluate requests every cycle.
  - SERVE_I, SERVE_D: one transaction in flight.
- Grant rule in IDLE:
  - I pending and streak == STARVE_LIMIT -> SERVE_I.
  - Otherwise any D request -> SERVE_D.
  - Otherwise i_read -> SERVE_I.
  - Otherwise stay in IDLE.
- Latch on grant edge: requester address → pmem_address. For D: d_wdata → pmem_wdata; d_write → pmem_write, else pmem_read.
- d_read and d_write asserted together: treated as write; pmem_read stays 0.
- Strobes stay asserted for the whole SERVE state. Address and data are held constant even if requester inputs change mid-transaction.
- Completion: in SERVE_x with pmem_resp=1:
  - x_resp=1 in the same cycle (combinational from state & pmem_resp).
  - x_rdata = pmem_rdata.
  - State returns to IDLE on the next edge; strobes drop to 0 on that edge.
- pmem_resp in IDLE is ignored: no resp asserted, no state change.
- Data passthrough: i_rdata and d_rdata are continuous copies of pmem_rdata; only the resp pulse qualifies them.
- Latency:
  - Request seen in IDLE at cycle N -> strobe at N+1.
  - Minimum 1 IDLE cycle between back-to-back transactions (turnaround).
  - Zero-wait memory (resp at N+1) -> resp at N+1, next grant at N+2.
- Streak counter (4-bit):
  - +1 on each SERVE_D grant made while i_read=1.
  - Cleared on any SERVE_I grant.
  - Cleared on a SERVE_D grant with i_read=0.
  - Saturates at STARVE_LIMIT; never wraps.
- Requester contract: a request deasserted before its resp is protocol violation. The arbiter completes the memory transaction anyway and pulses resp; no assertion is required.
- Reset mid-transaction: next edge forces IDLE, strobes 0, counter 0. A pmem_resp arriving in the reset cycle or after produces no resp pulse.

Test Plan:
- Single I read: i_read=1, addr 0x1230, pmem_resp 3 cycles after strobe -> pmem_read=1, pmem_address=0x1230 from next cycle; i_resp pulses 1 cycle with i_rdata=pmem_rdata; pmem_read=0 the following cycle.
- Simultaneous i_read and d_write in IDLE, d_address 0x4000, d_wdata 0xDEAD...BEEF -> SERVE_D first with pmem_write=1 and matching data; then IDLE one cycle, then SERVE_I; both resp pulse exactly once.
- Starvation, STARVE_LIMIT=4: i_read held and d_read re-asserted continuously -> exactly 4 D transactions, then I granted, counter back to 0.
- Input change mid-transaction: change d_address and d_wdata while in SERVE_D -> pmem_address and pmem_wdata unchanged until completion.
- Reset mid-transaction: rst=1 for 1 cycle during SERVE_I, pmem_resp pulsed that cycle -> no i_resp; pmem_read=0 next cycle; state IDLE.
- Spurious resp: pmem_resp=1 in IDLE with no requests -> i_resp=d_resp=0; strobes remain 0.
